// File: rtl/neuron_seq_if.sv
// Handshake and datapath bundle between neuron_seq and its environment.
// With NEURON_SEQ_ACC_SAT_EN defined the bundle also carries sat_flag.
interface neuron_seq_if #(
  parameter int PARALLEL_IN = 4,
  parameter int DIN1_WIDTH  = 16,
  parameter int DIN2_WIDTH  = 16,
  parameter int SUM_WIDTH   = 32,
  parameter int ACC_WIDTH   = 40,
  parameter int MAX_CHUNKS  = 64
);
  localparam int CNT_WIDTH = $clog2(MAX_CHUNKS + 1);

  logic                              start;
  logic [CNT_WIDTH-1:0]              n_chunks;
  logic                              busy;
  logic [DIN1_WIDTH*PARALLEL_IN-1:0] din1;
  logic [DIN2_WIDTH*PARALLEL_IN-1:0] din2;
  logic                              din_valid;
  logic                              din_ready;
  logic [DIN1_WIDTH*PARALLEL_IN-1:0] ma_din1;
  logic [DIN2_WIDTH*PARALLEL_IN-1:0] ma_din2;
  logic [SUM_WIDTH-1:0]              ma_dout;
  logic [ACC_WIDTH-1:0]              dout;
  logic                              dout_valid;
`ifdef NEURON_SEQ_ACC_SAT_EN
  logic                              sat_flag;
`endif

  modport master (
    output start, n_chunks, din1, din2, din_valid, ma_dout,
    input  busy, din_ready, ma_din1, ma_din2, dout, dout_valid
`ifdef NEURON_SEQ_ACC_SAT_EN
    , sat_flag
`endif
  );

  modport slave (
    input  start, n_chunks, din1, din2, din_valid, ma_dout,
    output busy, din_ready, ma_din1, ma_din2, dout, dout_valid
`ifdef NEURON_SEQ_ACC_SAT_EN
    , sat_flag
`endif
  );
endinterface

// File: rtl/neuron_seq.sv
// Sequencer feeding one mult_add datapath and accumulating its partial sums.
// Define NEURON_SEQ_ACC_SAT_EN for a saturating accumulator with sat_flag.
module neuron_seq #(
  parameter int PARALLEL_IN = 4,
  parameter int DIN1_WIDTH  = 16,
  parameter int DIN2_WIDTH  = 16,
  parameter int SUM_WIDTH   = 32,
  parameter int ACC_WIDTH   = 40,
  parameter int MAX_CHUNKS  = 64,
  parameter int PIPE_LAT    = 4
) (
  input logic         clk,
  input logic         rst,
  neuron_seq_if.slave bus
);
  localparam int CNT_WIDTH = $clog2(MAX_CHUNKS + 1);
  localparam int D1W       = DIN1_WIDTH * PARALLEL_IN;
  localparam int D2W       = DIN2_WIDTH * PARALLEL_IN;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  state_e                        state_q, state_d;
  logic [CNT_WIDTH-1:0]          n_q, n_d;
  logic [CNT_WIDTH-1:0]          sent_q, sent_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [PIPE_LAT:0]             tag_q, tag_d;
  logic [D1W-1:0]                ma_din1_q, ma_din1_d;
  logic [D2W-1:0]                ma_din2_q, ma_din2_d;
  logic [ACC_WIDTH-1:0]          dout_q, dout_d;
  logic                          dout_valid_q, dout_valid_d;

  logic                          accept;
  logic [CNT_WIDTH-1:0]          sent_inc;
  logic signed [ACC_WIDTH-1:0]   addend, wrap_sum, acc_next;

  assign accept   = (state_q == FEED) && bus.din_valid;
  assign sent_inc = sent_q + CNT_WIDTH'(1);
  assign addend   = ACC_WIDTH'($signed(bus.ma_dout));
  assign wrap_sum = acc_q + addend;

`ifdef NEURON_SEQ_ACC_SAT_EN
  logic sat_q, sat_d;
  logic ovf;
  // Overflow only when both operands share a sign the result does not.
  assign ovf = (acc_q[ACC_WIDTH-1] == addend[ACC_WIDTH-1]) &&
               (wrap_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
  assign acc_next = !ovf               ? wrap_sum :
                    acc_q[ACC_WIDTH-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                         {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
  assign acc_next = wrap_sum;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    n_d          = n_q;
    sent_d       = sent_q;
    acc_d        = acc_q;
    ma_din1_d    = '0;
    ma_din2_d    = '0;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    tag_d        = {tag_q[PIPE_LAT-1:0], accept};
`ifdef NEURON_SEQ_ACC_SAT_EN
    sat_d        = sat_q;
`endif

    // The oldest tag lines up with the datapath result of that beat.
    if (tag_q[PIPE_LAT]) begin
      acc_d = acc_next;
`ifdef NEURON_SEQ_ACC_SAT_EN
      sat_d = sat_q | ovf;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = bus.n_chunks;
          sent_d  = '0;
          acc_d   = '0;
          state_d = (bus.n_chunks == '0) ? DRAIN : FEED;
`ifdef NEURON_SEQ_ACC_SAT_EN
          sat_d   = 1'b0;
`endif
        end
      end
      FEED: begin
        if (accept) begin
          ma_din1_d = bus.din1;
          ma_din2_d = bus.din2;
          sent_d    = sent_inc;
          if (sent_inc == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (tag_q == '0) state_d = DONE;
      end
      DONE: begin
        dout_d       = acc_q;
        dout_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the tag pipe is reset along with control state; stale tags would add ghost beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      sent_q       <= '0;
      acc_q        <= '0;
      tag_q        <= '0;
      ma_din1_q    <= '0;
      ma_din2_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
`ifdef NEURON_SEQ_ACC_SAT_EN
      sat_q        <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q      <= state_d;
      n_q          <= n_d;
      sent_q       <= sent_d;
      acc_q        <= acc_d;
      tag_q        <= tag_d;
      ma_din1_q    <= ma_din1_d;
      ma_din2_q    <= ma_din2_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef NEURON_SEQ_ACC_SAT_EN
      sat_q        <= sat_d;
`endif
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.din_ready  = (state_q == FEED);
  assign bus.ma_din1    = ma_din1_q;
  assign bus.ma_din2    = ma_din2_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
`ifdef NEURON_SEQ_ACC_SAT_EN
  assign bus.sat_flag   = sat_q;
`endif
endmodule

// File: tb/tb_neuron_seq.sv
// Directed bench for neuron_seq: a 40-bit accumulator instance for the main
// scenarios and a 32-bit one for wrap/saturation (NEURON_SEQ_ACC_SAT_EN aware).
module tb_neuron_seq;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  neuron_seq_if #(.ACC_WIDTH(40)) bus   ();
  neuron_seq_if #(.ACC_WIDTH(32)) bus32 ();

  neuron_seq #(.ACC_WIDTH(40), .PIPE_LAT(LAT)) dut   (.clk(clk), .rst(rst), .bus(bus));
  neuron_seq #(.ACC_WIDTH(32), .PIPE_LAT(LAT)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  function automatic longint dot(input logic [63:0] a, input logic [63:0] b);
    longint s = 0;
    for (int i = 0; i < 4; i++)
      s += longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*16 +: 16]));
    return s;
  endfunction

  function automatic logic [63:0] pk(input int e0, input int e1, input int e2, input int e3);
    return {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
  endfunction

  // Datapath stand-in: dot product of the registered chunk, LAT cycles later.
  logic [31:0] dp_pipe   [LAT];
  logic [31:0] dp_pipe32 [LAT];
  always @(posedge clk) begin
    dp_pipe[0]   <= 32'(dot(bus.ma_din1, bus.ma_din2));
    dp_pipe32[0] <= 32'(dot(bus32.ma_din1, bus32.ma_din2));
    for (int i = 1; i < LAT; i++) begin
      dp_pipe[i]   <= dp_pipe[i-1];
      dp_pipe32[i] <= dp_pipe32[i-1];
    end
  end
  assign bus.ma_dout   = dp_pipe[LAT-1];
  assign bus32.ma_dout = dp_pipe32[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_dv(input bit sel, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(sel ? bus32.dout_valid : bus.dout_valid) && cycles < budget);
  endtask

  int cyc;
  int busy_cnt;
  int dv_cnt;
  bit ready_seen;

  initial begin
    bus.start = 1'b0;   bus.n_chunks = '0;   bus.din_valid = 1'b0;
    bus.din1 = '0;      bus.din2 = '0;
    bus32.start = 1'b0; bus32.n_chunks = '0; bus32.din_valid = 1'b0;
    bus32.din1 = '0;    bus32.din2 = '0;
    tick(); tick();
    rst = 1'b1;

    check("rst_busy",       64'(bus.busy), 0);
    check("rst_din_ready",  64'(bus.din_ready), 0);
    check("rst_dout",       64'(bus.dout), 0);
    check("rst_dout_valid", 64'(bus.dout_valid), 0);
    check("rst_ma_din1",    bus.ma_din1, 0);
`ifdef NEURON_SEQ_ACC_SAT_EN
    check("rst_sat_flag",   64'(bus32.sat_flag), 0);
`endif

    // Three chunks back to back, each summing to 24.
    bus.start = 1'b1; bus.n_chunks = 7'd3;
    bus.din1 = pk(2, 2, 2, 2); bus.din2 = pk(3, 3, 3, 3); bus.din_valid = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t1_busy_after_start", 64'(bus.busy), 1);
    check("t1_ready_in_feed",    64'(bus.din_ready), 1);
    tick();
    wait_dv(1'b0, 40, cyc);
    bus.din_valid = 1'b0;
    check("t1_latency",    64'(cyc), 3 + LAT + 2);
    check("t1_dout",       64'(bus.dout), 72);
    check("t1_dout_valid", 64'(bus.dout_valid), 1);
    tick();
    check("t1_pulse_width", 64'(bus.dout_valid), 0);
    check("t1_dout_hold",   64'(bus.dout), 72);
    check("t1_idle_busy",   64'(bus.busy), 0);

    // Empty vector.
    bus.start = 1'b1; bus.n_chunks = 7'd0;
    tick();
    bus.start = 1'b0;
    busy_cnt = 0; dv_cnt = 0; ready_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.dout_valid) dv_cnt++;
      ready_seen |= bus.din_ready;
      tick();
    end
    check("t3_busy_cycles", 64'(busy_cnt), 2);
    check("t3_dv_count",    64'(dv_cnt), 1);
    check("t3_ready_never", 64'(ready_seen), 0);
    check("t3_dout",        64'(bus.dout), 0);

    // Four chunks with bubbles: 10, -5, 7, 1.
    bus.start = 1'b1; bus.n_chunks = 7'd4;
    tick();
    bus.start = 1'b0;
    bus.din1 = pk(1, 1, 1, 1);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: bus.din2 = pk(1, 2, 3, 4);
        1: bus.din2 = pk(-2, -3, 0, 0);
        2: bus.din2 = pk(3, 4, 0, 0);
        default: bus.din2 = pk(1, 0, 0, 0);
      endcase
      bus.din_valid = 1'b1;
      tick();
      bus.din_valid = 1'b0;
      bus.din2 = pk(99, 99, 99, 99);
      check($sformatf("t2_ready_after_%0d", k), 64'(bus.din_ready), (k == 3) ? 0 : 1);
      tick();
    end
    wait_dv(1'b0, 40, cyc);
    check("t2_dout_valid", 64'(bus.dout_valid), 1);
    check("t2_dout",       64'(bus.dout), 13);

    // Reset after two of five chunks, then a clean one-chunk vector.
    bus.start = 1'b1; bus.n_chunks = 7'd5;
    tick();
    bus.start = 1'b0;
    bus.din1 = pk(10, 10, 0, 0); bus.din2 = pk(5, 5, 0, 0); bus.din_valid = 1'b1;
    tick(); tick();
    rst = 1'b0; bus.din_valid = 1'b0;
    tick();
    check("t4_busy",       64'(bus.busy), 0);
    check("t4_din_ready",  64'(bus.din_ready), 0);
    check("t4_dout",       64'(bus.dout), 0);
    check("t4_dout_valid", 64'(bus.dout_valid), 0);
    check("t4_ma_din1",    bus.ma_din1, 0);
    check("t4_ma_din2",    bus.ma_din2, 0);
    rst = 1'b1;
    bus.start = 1'b1; bus.n_chunks = 7'd1;
    tick();
    bus.start = 1'b0;
    bus.din1 = pk(3, 0, 0, 0); bus.din2 = pk(3, 0, 0, 0); bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    wait_dv(1'b0, 40, cyc);
    check("t4_dout_valid", 64'(bus.dout_valid), 1);
    check("t4_dout",       64'(bus.dout), 9);

    // Start pulses during FEED and DRAIN must be ignored.
    bus.start = 1'b1; bus.n_chunks = 7'd2;
    tick();
    bus.din1 = pk(1, 1, 1, 1); bus.din2 = pk(2, 1, 1, 1); bus.din_valid = 1'b1;
    bus.n_chunks = 7'd7;
    tick();
    bus.start = 1'b0;
    tick();
    bus.din_valid = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.n_chunks = 7'd2;
    dv_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.dout_valid) dv_cnt++;
      tick();
    end
    check("t5_dv_count", 64'(dv_cnt), 1);
    check("t5_dout",     64'(bus.dout), 10);
    check("t5_busy_end", 64'(bus.busy), 0);

    // 32-bit accumulator: two chunks of 0x7000_0000 each.
    bus32.start = 1'b1; bus32.n_chunks = 7'd2;
    tick();
    bus32.start = 1'b0;
    bus32.din1 = pk(-32768, -32768, -32768, -32768);
    bus32.din2 = pk(-32768, -16384, -8192, 0);
    bus32.din_valid = 1'b1;
    tick();
    wait_dv(1'b1, 40, cyc);
    bus32.din_valid = 1'b0;
    check("t6_latency", 64'(cyc), 2 + LAT + 2);
`ifdef NEURON_SEQ_ACC_SAT_EN
    check("t6_dout_sat", 64'(bus32.dout), 64'h7FFF_FFFF);
    check("t6_sat_flag", 64'(bus32.sat_flag), 1);
`else
    check("t6_dout_wrap", 64'(bus32.dout), 64'hE000_0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
